// File: rtl/sort_pkg.sv
// sort_pkg: shared constants, search state encoding and index-width helper
// for the sort / search block family.
package sort_pkg;

  localparam int unsigned SORT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_FINISH,
    S_DONE
  } search_state_e;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sorted_search_if.sv
// sorted_search_if: request/result bundle between a sorter and sorted_search.
// count exists only when SORTED_SEARCH_UPPER_EN is defined.
interface sorted_search_if import sort_pkg::*; #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = SORT_W_DEFAULT,
  parameter int unsigned IW = idx_width(N)
);
  logic           start;
  logic [W-1:0]   key;
  logic [N*W-1:0] data_in;
  logic           busy;
  logic           done;
  logic [IW-1:0]  index;
  logic           found;
`ifdef SORTED_SEARCH_UPPER_EN
  logic [IW-1:0]  count;

  modport master (output start, key, data_in, input busy, done, index, found, count);
  modport slave  (input start, key, data_in, output busy, done, index, found, count);
`else
  modport master (output start, key, data_in, input busy, done, index, found);
  modport slave  (input start, key, data_in, output busy, done, index, found);
`endif
endinterface

// File: rtl/sorted_search_bisect_step.sv
// bisect_step: one combinational bisection step over [lo,hi).
// upper=0 narrows toward the lower bound (<), upper=1 toward the upper bound (<=).
module bisect_step import sort_pkg::*; #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = SORT_W_DEFAULT,
  parameter int unsigned IW    = idx_width(N),
  parameter bit          upper = 1'b0
) (
  input  logic [IW-1:0]  lo,
  input  logic [IW-1:0]  hi,
  input  logic [N*W-1:0] arr,
  input  logic [W-1:0]   key,
  output logic [IW-1:0]  lo_nxt,
  output logic [IW-1:0]  hi_nxt
);
  logic [IW:0]   sum;
  logic [IW-1:0] mid;
  logic [IW-1:0] sel;
  logic [W-1:0]  elem;
  logic          go_right;

  always_comb begin
    sum      = {1'b0, lo} + {1'b0, hi};
    mid      = sum[IW:1];
    // mid only reaches N once lo==hi, where the step is a no-op anyway
    sel      = (mid < IW'(N)) ? mid : '0;
    elem     = arr[32'(sel) * W +: W];
    go_right = upper ? (elem <= key) : (elem < key);
    lo_nxt   = lo;
    hi_nxt   = hi;
    if (lo < hi) begin
      if (go_right) lo_nxt = mid + IW'(1);
      else          hi_nxt = mid;
    end
  end
endmodule

// File: rtl/sorted_search.sv
// sorted_search: fixed-latency lower-bound binary search over a packed ascending array.
// Define SORTED_SEARCH_UPPER_EN to run a parallel upper-bound pass and drive count.
module sorted_search import sort_pkg::*; #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = SORT_W_DEFAULT,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  sorted_search_if.slave bus
);
  localparam int unsigned ITER = idx_width(N);

  search_state_e  state, state_nxt;
  logic [N*W-1:0] arr_q;
  logic [W-1:0]   key_q;
  logic [IW-1:0]  lo, hi, lo_nxt, hi_nxt, step, index_q, lo_sel;
  logic [W-1:0]   lo_elem;
  logic           found_q, hit, accept, last_step;

  bisect_step #(.N(N), .W(W), .IW(IW), .upper(1'b0)) u_lower (
    .lo(lo), .hi(hi), .arr(arr_q), .key(key_q), .lo_nxt(lo_nxt), .hi_nxt(hi_nxt)
  );

  always_comb begin
    accept    = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
    last_step = (step == IW'(ITER - 1));
    lo_sel    = (lo < IW'(N)) ? lo : '0;
    lo_elem   = arr_q[32'(lo_sel) * W +: W];
    hit       = (lo < IW'(N)) && (lo_elem == key_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_nxt = S_SEARCH;
      S_SEARCH:       if (last_step) state_nxt = S_FINISH;
      S_FINISH:       state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_q   <= '0;
      key_q   <= '0;
      lo      <= '0;
      hi      <= '0;
      step    <= '0;
      index_q <= '0;
      found_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          arr_q <= bus.data_in;
          key_q <= bus.key;
          lo    <= '0;
          hi    <= IW'(N);
          step  <= '0;
        end
        S_SEARCH: begin
          lo   <= lo_nxt;
          hi   <= hi_nxt;
          step <= step + IW'(1);
        end
        S_FINISH: begin
          index_q <= lo;
          found_q <= hit;
        end
        default: ;
      endcase
    end
  end

`ifdef SORTED_SEARCH_UPPER_EN
  logic [IW-1:0] lo2, hi2, lo2_nxt, hi2_nxt, count_q;

  bisect_step #(.N(N), .W(W), .IW(IW), .upper(1'b1)) u_upper (
    .lo(lo2), .hi(hi2), .arr(arr_q), .key(key_q), .lo_nxt(lo2_nxt), .hi_nxt(hi2_nxt)
  );

  // Upper-bound pair shadows the lower pair cycle for cycle; count = ub - lb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo2     <= '0;
      hi2     <= '0;
      count_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          lo2 <= '0;
          hi2 <= IW'(N);
        end
        S_SEARCH: begin
          lo2 <= lo2_nxt;
          hi2 <= hi2_nxt;
        end
        S_FINISH: count_q <= lo2 - lo;
        default: ;
      endcase
    end
  end
`else
  // Lower-bound search only; no count register.
`endif

  always_comb begin
    bus.busy  = (state == S_SEARCH) || (state == S_FINISH);
    bus.done  = (state == S_DONE);
    bus.index = index_q;
    bus.found = found_q;
`ifdef SORTED_SEARCH_UPPER_EN
    bus.count = count_q;
`endif
  end
endmodule

// File: tb/tb_sorted_search.sv
// tb_sorted_search: scoreboard bench for sorted_search (N=8, W=8); count checked
// only when SORTED_SEARCH_UPPER_EN is defined.
module tb_sorted_search;
  import sort_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  typedef struct {
    logic [3:0] idx;
    logic       fnd;
    logic [3:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] arr [8];
  exp_t       sb [$];
  int         n_cmp;
  int         n_err;

  sorted_search_if #(.N(N), .W(W)) bus ();

  sorted_search #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference by linear scan: lower bound = #elements < key, upper = #elements <= key.
  function automatic exp_t model(input logic [7:0] k);
    int unsigned lb;
    int unsigned ub;
    exp_t e;
    lb = 0;
    ub = 0;
    for (int i = 0; i < 8; i++) begin
      if (arr[3'(i)] <  k) lb++;
      if (arr[3'(i)] <= k) ub++;
    end
    e.idx = 4'(lb);
    e.fnd = 1'b0;
    if (lb < 8) e.fnd = (arr[3'(lb)] == k);
    e.cnt = 4'(ub - lb);
    return e;
  endfunction

  task automatic load_arr(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    arr[0] = a0; arr[1] = a1; arr[2] = a2; arr[3] = a3;
    arr[4] = a4; arr[5] = a5; arr[6] = a6; arr[7] = a7;
    for (int i = 0; i < 8; i++) bus.data_in[i*8 +: 8] = arr[3'(i)];
  endtask

  // Drives start with key, pushes the expectation, returns #1 after the accepting edge.
  task automatic start_search(input logic [7:0] k, input bit hold, input string tag);
    bus.key   = k;
    bus.start = 1'b1;
    sb.push_back(model(k));
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, 32'(bus.busy), 1);
    check({tag, "_done_e0"}, 32'(bus.done), 0);
    if (!hold) bus.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; optionally pokes inputs mid-search.
  task automatic wait_done(input string tag, input int poke_at, input bit poke_start,
                           input logic [7:0] poke_key, input bit poke_data);
    int edges;
    int busy_cyc;
    edges    = 0;
    busy_cyc = 1;
    while (edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (edges == poke_at) begin
        if (poke_start) begin
          bus.start = 1'b1;
          bus.key   = poke_key;
        end
        if (poke_data) bus.data_in = '0;
      end
      if (edges == poke_at + 1 && poke_start) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) busy_cyc++;
    end
    check({tag, "_latency"}, 32'(edges), 5);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 5);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 0);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_index"}, 32'(bus.index), 32'(e.idx));
      check({tag, "_found"}, 32'(bus.found), 32'(e.fnd));
`ifdef SORTED_SEARCH_UPPER_EN
      check({tag, "_count"}, 32'(bus.count), 32'(e.cnt));
`endif
    end
  endtask

  task automatic one_search(input logic [7:0] k, input string tag);
    start_search(k, 1'b0, tag);
    wait_done(tag, -1, 1'b0, 8'h00, 1'b0);
    compare_result(tag);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.key     = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(bus.busy),  0);
    check("rst_done",  32'(bus.done),  0);
    check("rst_index", 32'(bus.index), 0);
    check("rst_found", 32'(bus.found), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_arr(8'd3, 8'd5, 8'd5, 8'd5, 8'd9, 8'd12, 8'd20, 8'd255);
    one_search(8'd5,   "k5");
    one_search(8'd6,   "k6");
    one_search(8'd0,   "k0");
    one_search(8'd255, "k255");

    load_arr(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    one_search(8'd200, "past_end");

    // start with another key during SEARCH must be ignored
    load_arr(8'd3, 8'd5, 8'd5, 8'd5, 8'd9, 8'd12, 8'd20, 8'd255);
    start_search(8'd5, 1'b0, "ign");
    wait_done("ign", 2, 1'b1, 8'd20, 1'b0);
    compare_result("ign");

    // start held in DONE: restart with done high for only one cycle
    start_search(8'd12, 1'b1, "hold1");
    wait_done("hold1", -1, 1'b0, 8'h00, 1'b0);
    compare_result("hold1");
    sb.push_back(model(8'd12));
    @(posedge clk); #1;
    check("hold_gap_done", 32'(bus.done), 0);
    check("hold_gap_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    wait_done("hold2", -1, 1'b0, 8'h00, 1'b0);
    compare_result("hold2");

    // data_in changed after capture has no effect
    start_search(8'd20, 1'b0, "datachg");
    wait_done("datachg", 2, 1'b0, 8'h00, 1'b1);
    compare_result("datachg");
    load_arr(8'd3, 8'd5, 8'd5, 8'd5, 8'd9, 8'd12, 8'd20, 8'd255);

    // asynchronous reset mid-SEARCH clears outputs before the next edge
    start_search(8'd9, 1'b0, "rstmid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy",  32'(bus.busy),  0);
    check("rstmid_done",  32'(bus.done),  0);
    check("rstmid_index", 32'(bus.index), 0);
    check("rstmid_found", 32'(bus.found), 0);
`ifdef SORTED_SEARCH_UPPER_EN
    check("rstmid_count", 32'(bus.count), 0);
`endif
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    one_search(8'd9, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
